// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes, default datapath width and response-checker state type
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SHL = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational expected result of the ALU for a given select
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_sel,
  output logic [WIDTH-1:0] o_y
);
  always_comb
    o_y = (i_sel == ALU_ADD) ? i_a + i_b :
          (i_sel == ALU_SUB) ? i_a - i_b :
          (i_sel == ALU_AND) ? i_a & i_b :
          (i_sel == ALU_OR)  ? i_a | i_b :
          (i_sel == ALU_XOR) ? i_a ^ i_b :
          (i_sel == ALU_NOR) ? ~(i_a | i_b) :
          (i_sel == ALU_SLT) ? WIDTH'($signed(i_a) < $signed(i_b)) :
                               i_a << i_b[4:0];
endmodule

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: ALU response checker / BIST compactor; ALU_RESP_CHECKER_OPMASK_EN adds per-select error flags
module alu_resp_checker
  import alu_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act,
  output logic [7:0]       err_op_mask
);
  chk_state_t       r_state;
  logic             r_s1_valid;
  logic [CNT_W-1:0] r_s1_idx, r_vec_count, r_err_count, r_first_idx;
  logic [WIDTH-1:0] r_s1_exp, r_s1_act, r_first_exp, r_first_act;
  logic [WIDTH-1:0] w_exp;
  logic             w_acc, w_mis, w_start, w_last;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (.i_a(in_a), .i_b(in_b), .i_sel(in_sel), .o_y(w_exp));

  assign in_ready = (r_state == RUN) && (r_vec_count < CNT_W'(NUM_VECTORS));
  assign w_acc    = in_valid && in_ready;
  assign w_mis    = r_s1_valid && (r_s1_exp != r_s1_act);
  assign w_start  = start && (r_state != RUN);
  assign w_last   = r_s1_valid && (r_s1_idx == CNT_W'(NUM_VECTORS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s1_valid  <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_exp    <= '0;
      r_s1_act    <= '0;
      r_vec_count <= '0;
      r_err_count <= '0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
    end else begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_idx    <= r_vec_count;
        r_s1_exp    <= w_exp;
        r_s1_act    <= in_result;
        r_vec_count <= r_vec_count + 1'b1;
      end
      if (w_mis) begin
        r_err_count <= (r_err_count == '1) ? r_err_count : r_err_count + 1'b1;
        if (r_err_count == '0) begin
          r_first_idx <= r_s1_idx;
          r_first_exp <= r_s1_exp;
          r_first_act <= r_s1_act;
        end
      end
      // a new run wipes every result of the previous one
      if (w_start) begin
        r_state     <= RUN;
        r_vec_count <= '0;
        r_err_count <= '0;
        r_first_idx <= '0;
        r_first_exp <= '0;
        r_first_act <= '0;
      end else if (r_state == RUN && w_last) begin
        r_state <= DONE;
      end
    end
  end

  assign busy          = (r_state == RUN);
  assign done          = (r_state == DONE);
  assign pass          = done && (r_err_count == '0);
  assign vec_count     = r_vec_count;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_idx;
  assign first_err_exp = r_first_exp;
  assign first_err_act = r_first_act;

`ifdef ALU_RESP_CHECKER_OPMASK_EN
  logic [2:0] r_s1_sel;
  logic [7:0] r_op_mask;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_sel  <= '0;
      r_op_mask <= '0;
    end else begin
      if (w_acc) r_s1_sel <= in_sel;
      r_op_mask <= w_start ? '0 : w_mis ? r_op_mask | (8'd1 << r_s1_sel) : r_op_mask;
    end
  end
  assign err_op_mask = r_op_mask;
`else
  assign err_op_mask = '0;
`endif
endmodule
